// File: rtl/dft_out_pkg.sv
// Shared definitions for the DFT output formatting stage: FSM encoding,
// frame-length limits and the symmetric saturation limit.
package dft_out_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fmt_state_e;

  localparam int unsigned MAX_LEN   = 2048;
  localparam int unsigned IDX_WIDTH = 11;
  localparam int unsigned LEN_WIDTH = 12;

  // Largest magnitude an output of width w may carry; the most negative code is never used.
  function automatic longint sat_lim(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/dft_bfp_shift.sv
// Signed shift / round-half-away-from-zero / symmetric saturate of one mantissa.
// The sat flag exists only when DFT_OUT_SAT_CNT_EN is defined.
module dft_bfp_shift
  import dft_out_pkg::*;
#(
  parameter int unsigned MAN_WIDTH = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SH_WIDTH  = 10
) (
  input  logic signed [MAN_WIDTH-1:0] man,
  input  logic signed [SH_WIDTH-1:0]  shift,
`ifdef DFT_OUT_SAT_CNT_EN
  output logic                        sat,
`endif
  output logic signed [OUT_WIDTH-1:0] res
);

  localparam int unsigned W = MAN_WIDTH + OUT_WIDTH + 2;
  localparam logic signed [W-1:0] LIM  = W'(sat_lim(OUT_WIDTH));
  localparam logic signed [W-1:0] NLIM = -LIM;

  logic signed [W-1:0]   ext;
  logic signed [W-1:0]   bias;
  logic signed [W-1:0]   wide;
  logic [SH_WIDTH-1:0]   mag;
  logic [SH_WIDTH-1:0]   amt;
  logic                  clip;

  always_comb begin
    ext  = W'(man);
    mag  = shift[SH_WIDTH-1] ? $unsigned(-shift) : $unsigned(shift);
    amt  = '0;
    bias = '0;
    wide = '0;
    clip = 1'b0;
    res  = '0;
    if (!shift[SH_WIDTH-1]) begin
      amt  = (mag > SH_WIDTH'(OUT_WIDTH)) ? SH_WIDTH'(OUT_WIDTH) : mag;
      wide = ext <<< amt;
    end else begin
      // Clamping to MAN_WIDTH+1 keeps the bias below the shift range, so the result rounds to 0.
      amt  = (mag > SH_WIDTH'(MAN_WIDTH + 1)) ? SH_WIDTH'(MAN_WIDTH + 1) : mag;
      bias = (W'(1) <<< (amt - SH_WIDTH'(1))) - (man[MAN_WIDTH-1] ? W'(1) : W'(0));
      wide = (ext + bias) >>> amt;
    end
    if (wide > LIM) begin
      res  = LIM[OUT_WIDTH-1:0];
      clip = 1'b1;
    end else if (wide < NLIM) begin
      res  = NLIM[OUT_WIDTH-1:0];
      clip = 1'b1;
    end else begin
      res  = wide[OUT_WIDTH-1:0];
    end
  end

`ifdef DFT_OUT_SAT_CNT_EN
  assign sat = clip;
`endif

endmodule

// File: rtl/dft_out_fmt.sv
// DFT output formatter: block-floating-point to fixed-point with frame tagging.
// Optional per-frame saturation counter enabled by DFT_OUT_SAT_CNT_EN.
`ifndef FFT_OUT_WIDTH
`define FFT_OUT_WIDTH 16
`endif
`ifndef FFT_OUT_PTPOS
`define FFT_OUT_PTPOS 10
`endif

module dft_out_fmt
  import dft_out_pkg::*;
#(
  parameter int unsigned MAN_WIDTH = 16,
  parameter int unsigned EXP_WIDTH = 5,
  parameter int unsigned OUT_WIDTH = `FFT_OUT_WIDTH,
  parameter int          OUT_PTPOS = `FFT_OUT_PTPOS
) (
  input  logic                        clk_sys,
  input  logic                        rst_sys_n,
  input  logic                        sof_i,
  input  logic                        val_i,
  input  logic signed [MAN_WIDTH-1:0] man_real_i,
  input  logic signed [MAN_WIDTH-1:0] man_imag_i,
  input  logic signed [EXP_WIDTH-1:0] exp_i,
  input  logic [LEN_WIDTH-1:0]        trans_len_i,
  output logic                        block_sync_o,
  output logic                        data_val_o,
  output logic signed [OUT_WIDTH-1:0] data_real_o,
  output logic signed [OUT_WIDTH-1:0] data_imag_o,
  output logic [LEN_WIDTH-1:0]        trans_len_o,
  output logic [IDX_WIDTH-1:0]        data_index_o,
`ifdef DFT_OUT_SAT_CNT_EN
  output logic [15:0]                 sat_cnt_o,
`endif
  output logic                        frm_err_o
);

  localparam int unsigned SH_WIDTH = EXP_WIDTH + 5;

  fmt_state_e                 state, state_nxt;
  logic [IDX_WIDTH-1:0]       cnt, idx_nxt;
  logic [LEN_WIDTH-1:0]       len_r;
  logic signed [SH_WIDTH-1:0] shift_r, shift_new;
  logic                       len_ok, accept, load, err_set;

  logic                       s1_val, s1_sof;
  logic [IDX_WIDTH-1:0]       s1_idx;
  logic [LEN_WIDTH-1:0]       s1_len;
  logic signed [MAN_WIDTH-1:0] s1_re, s1_im;
  logic signed [SH_WIDTH-1:0] s1_shift;
  logic signed [OUT_WIDTH-1:0] res_re, res_im;

  assign shift_new = SH_WIDTH'(exp_i) + SH_WIDTH'(OUT_PTPOS - int'(MAN_WIDTH) + 1);
  assign len_ok    = (trans_len_i != '0) && (trans_len_i <= LEN_WIDTH'(MAX_LEN));

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    err_set   = 1'b0;
    idx_nxt   = cnt;
    if (val_i && sof_i) begin
      // Any sof while running is early: RUN is left as soon as index len-1 is taken.
      if (state == ST_RUN) err_set = 1'b1;
      if (len_ok) begin
        load      = 1'b1;
        accept    = 1'b1;
        idx_nxt   = '0;
        state_nxt = (trans_len_i == LEN_WIDTH'(1)) ? ST_IDLE : ST_RUN;
      end else begin
        err_set   = 1'b1;
        state_nxt = ST_IDLE;
      end
    end else if (val_i) begin
      if (state == ST_RUN) begin
        accept  = 1'b1;
        idx_nxt = cnt + IDX_WIDTH'(1);
        if ({1'b0, idx_nxt} == len_r - LEN_WIDTH'(1)) state_nxt = ST_IDLE;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cnt       <= '0;
      len_r     <= '0;
      shift_r   <= '0;
      frm_err_o <= 1'b0;
      s1_val    <= 1'b0;
      s1_sof    <= 1'b0;
      s1_idx    <= '0;
      s1_len    <= '0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_shift  <= '0;
    end else begin
      frm_err_o <= frm_err_o | err_set;
      s1_val    <= accept;
      s1_sof    <= accept & sof_i;
      if (load) begin
        len_r   <= trans_len_i;
        shift_r <= shift_new;
      end
      if (accept) begin
        cnt      <= idx_nxt;
        s1_idx   <= idx_nxt;
        s1_re    <= man_real_i;
        s1_im    <= man_imag_i;
        s1_shift <= load ? shift_new : shift_r;
        s1_len   <= load ? trans_len_i : len_r;
      end
    end
  end

`ifdef DFT_OUT_SAT_CNT_EN
  logic sat_re, sat_im;
`endif

  dft_bfp_shift #(.MAN_WIDTH(MAN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SH_WIDTH(SH_WIDTH)) u_shift_re (
    .man   (s1_re),
    .shift (s1_shift),
`ifdef DFT_OUT_SAT_CNT_EN
    .sat   (sat_re),
`endif
    .res   (res_re)
  );

  dft_bfp_shift #(.MAN_WIDTH(MAN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SH_WIDTH(SH_WIDTH)) u_shift_im (
    .man   (s1_im),
    .shift (s1_shift),
`ifdef DFT_OUT_SAT_CNT_EN
    .sat   (sat_im),
`endif
    .res   (res_im)
  );

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      data_val_o   <= 1'b0;
      block_sync_o <= 1'b0;
      data_real_o  <= '0;
      data_imag_o  <= '0;
      data_index_o <= '0;
      trans_len_o  <= '0;
    end else begin
      data_val_o   <= s1_val;
      block_sync_o <= s1_sof;
      if (s1_val) begin
        data_real_o  <= res_re;
        data_imag_o  <= res_im;
        data_index_o <= s1_idx;
      end
      if (s1_sof) trans_len_o <= s1_len;
    end
  end

`ifdef DFT_OUT_SAT_CNT_EN
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sat_cnt_o <= '0;
    end else if (s1_val) begin
      if (s1_sof)                                  sat_cnt_o <= {15'd0, sat_re | sat_im};
      else if ((sat_re | sat_im) && sat_cnt_o != '1) sat_cnt_o <= sat_cnt_o + 16'd1;
    end
  end
`endif

endmodule
